// File: rtl/iob_uart16550_stream_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart16550_stream_ctl_pkg
// Purpose  : Register map, line-control constants, FSM encoding and the
//            power-up programming table for the 16550 stream controller.
// Revision : 1.0 - initial release
// ============================================================================
package iob_uart16550_stream_ctl_pkg;

  // 16550 register byte addresses
  localparam logic [2:0] ADDR_RBR = 3'd0;
  localparam logic [2:0] ADDR_THR = 3'd0;
  localparam logic [2:0] ADDR_IER = 3'd1;
  localparam logic [2:0] ADDR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR = 3'd3;
  localparam logic [2:0] ADDR_LSR = 3'd5;
  localparam logic [2:0] ADDR_DLL = 3'd0;
  localparam logic [2:0] ADDR_DLM = 3'd1;

  // Register values written during initialisation
  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_EN       = 8'h07;
  localparam logic [7:0] IER_OFF      = 8'h00;

  // Line Status Register bit positions
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;

  // Index of the final write of the init sequence
  localparam logic [2:0] INIT_LAST = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_POLL_REQ  = 3'd2,
    ST_POLL_WAIT = 3'd3,
    ST_RX_REQ    = 3'd4,
    ST_RX_WAIT   = 3'd5,
    ST_TX_WR     = 3'd6
  } state_e;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } reg_wr_t;

  // Returns the (address, data) pair for one step of the init sequence:
  // DLAB on, divisor low/high, 8N1 with DLAB off, FIFOs on, interrupts off.
  function automatic reg_wr_t init_step(input logic [2:0] step, input logic [15:0] div);
    reg_wr_t r;
    case (step)
      3'd0:    r = '{addr: ADDR_LCR, data: LCR_DLAB_8N1};
      3'd1:    r = '{addr: ADDR_DLL, data: div[7:0]};
      3'd2:    r = '{addr: ADDR_DLM, data: div[15:8]};
      3'd3:    r = '{addr: ADDR_LCR, data: LCR_8N1};
      3'd4:    r = '{addr: ADDR_FCR, data: FCR_EN};
      default: r = '{addr: ADDR_IER, data: IER_OFF};
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_uart16550_stream_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart16550_stream_ctl_if
// Purpose  : IOb native bus between the stream controller (master) and the
//            16550 UART wrapper (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface iob_uart16550_stream_ctl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic                  iob_avalid;
  logic [ADDR_W-1:0]     iob_addr;
  logic [DATA_W-1:0]     iob_wdata;
  logic [DATA_W/8-1:0]   iob_wstrb;
  logic                  iob_ready;
  logic                  iob_rvalid;
  logic [DATA_W-1:0]     iob_rdata;

  modport master (
    output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_ready, iob_rvalid, iob_rdata
  );

  modport slave (
    input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
    output iob_ready, iob_rvalid, iob_rdata
  );
endinterface
`default_nettype wire

// File: rtl/iob_uart16550_stream_ctl_bus.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart16550_stream_ctl_bus
// Purpose  : Single-transaction IOb master. Latches one request, holds it
//            until ready, waits for rvalid on reads and pulses done_o. A
//            direct mode streams THR writes straight from the caller.
// Revision : 1.0 - initial release
// ============================================================================
module iob_uart16550_stream_ctl_bus #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  wire              clk_i,
  input  wire              cke_i,
  input  wire              arst_i,
  input  wire              start_i,
  input  wire              we_i,
  input  wire [ADDR_W-1:0] addr_i,
  input  wire [7:0]        wbyte_i,
  input  wire              direct_i,
  input  wire              direct_valid_i,
  input  wire [7:0]        direct_byte_i,
  output logic             done_o,
  output logic             accept_o,
  output logic [7:0]       rbyte_o,
  iob_uart16550_stream_ctl_if.master iob
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  logic              act_q;
  logic              wait_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        byte_q;

  logic [LANE_W-1:0] w_lane;
  logic              w_avalid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;

  assign w_lane = addr_q[LANE_W-1:0];

  // Request mux: latched request normally, the caller's stream in direct mode
  always_comb begin
    w_avalid = act_q;
    w_addr   = addr_q;
    w_wdata  = DATA_W'(byte_q) << {w_lane, 3'b000};
    w_wstrb  = (act_q && we_q) ? (STRB_W'(1) << w_lane) : '0;
    if (direct_i) begin
      w_avalid = direct_valid_i;
      w_addr   = '0;
      w_wdata  = DATA_W'(direct_byte_i);
      w_wstrb  = STRB_W'(1);
    end
  end

  assign iob.iob_avalid = w_avalid;
  assign iob.iob_addr   = w_addr;
  assign iob.iob_wdata  = w_wdata;
  assign iob.iob_wstrb  = w_wstrb;

  assign accept_o = w_avalid & iob.iob_ready;
  assign done_o   = (act_q & we_q & iob.iob_ready) | (wait_q & iob.iob_rvalid);
  assign rbyte_o  = iob.iob_rdata[{w_lane, 3'b000} +: 8];

  // Transaction tracker: idle -> request held -> (reads only) awaiting rvalid
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      act_q  <= 1'b0;
      wait_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      byte_q <= '0;
    end else if (cke_i) begin
      if (!act_q && !wait_q) begin
        if (start_i) begin
          act_q  <= 1'b1;
          we_q   <= we_i;
          addr_q <= addr_i;
          byte_q <= wbyte_i;
        end
      end else if (act_q) begin
        if (iob.iob_ready) begin
          act_q  <= 1'b0;
          wait_q <= ~we_q;
        end
      end else if (iob.iob_rvalid) begin
        wait_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_uart16550_stream_ctl.sv
`default_nettype none
// ============================================================================
// Module   : iob_uart16550_stream_ctl
// Purpose  : Programs a 16550 UART after reset, then polls LSR to move bytes
//            between valid/ready streams and THR/RBR.
// Revision : 1.0 - initial release
// ============================================================================
module iob_uart16550_stream_ctl
  import iob_uart16550_stream_ctl_pkg::*;
#(
  parameter int          ADDR_W   = 3,
  parameter int          DATA_W   = 32,
  parameter logic [15:0] DIVISOR  = 16'd27,
  parameter int          TX_BURST = 16
) (
  input  wire        clk_i,
  input  wire        cke_i,
  input  wire        arst_i,
  iob_uart16550_stream_ctl_if.master iob,
  input  wire        tx_valid_i,
  input  wire  [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  wire        rx_ready_i,
  output logic       init_done_o,
  output logic       rx_overrun_o
);

  localparam int BURST_W = $clog2(TX_BURST + 1);

  state_e             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               init_done_q, init_done_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               overrun_q, overrun_d;

  logic               w_start;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [7:0]         w_wbyte;
  logic               w_direct;
  logic               w_done;
  logic               w_accept;
  logic [7:0]         w_rbyte;
  reg_wr_t            w_init;

  assign w_init = init_step(step_q, DIVISOR);

  iob_uart16550_stream_ctl_bus #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus (
    .clk_i          (clk_i),
    .cke_i          (cke_i),
    .arst_i         (arst_i),
    .start_i        (w_start),
    .we_i           (w_we),
    .addr_i         (w_addr),
    .wbyte_i        (w_wbyte),
    .direct_i       (w_direct),
    .direct_valid_i (tx_valid_i),
    .direct_byte_i  (tx_data_i),
    .done_o         (w_done),
    .accept_o       (w_accept),
    .rbyte_o        (w_rbyte),
    .iob            (iob)
  );

  // Stream handshake is the bus handshake itself while bursting into THR
  assign tx_ready_o   = (state_q == ST_TX_WR) & w_accept;
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign init_done_o  = init_done_q;
  assign rx_overrun_o = overrun_q;

  // Next-state and bus-request decode
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    burst_d     = burst_q;
    init_done_d = init_done_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    overrun_d   = overrun_q;
    w_start     = 1'b0;
    w_we        = 1'b0;
    w_addr      = '0;
    w_wbyte     = '0;
    w_direct    = 1'b0;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_INIT: begin
        w_start = 1'b1;
        w_we    = 1'b1;
        w_addr  = ADDR_W'(w_init.addr);
        w_wbyte = w_init.data;
        state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (w_done) begin
          if (step_q == INIT_LAST) begin
            init_done_d = 1'b1;
            state_d     = ST_POLL_REQ;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_INIT;
          end
        end
      end
      ST_POLL_REQ: begin
        w_start = 1'b1;
        w_addr  = ADDR_W'(ADDR_LSR);
        state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (w_done) begin
          if (w_rbyte[LSR_OE]) begin
            overrun_d = 1'b1;
          end
          // Draining RX wins over TX so the receive FIFO cannot overflow
          if (w_rbyte[LSR_DR] && !rx_valid_q) begin
            state_d = ST_RX_REQ;
          end else if (w_rbyte[LSR_THRE] && tx_valid_i) begin
            burst_d = '0;
            state_d = ST_TX_WR;
          end else begin
            state_d = ST_POLL_REQ;
          end
        end
      end
      ST_RX_REQ: begin
        w_start = 1'b1;
        w_addr  = ADDR_W'(ADDR_RBR);
        state_d = ST_RX_WAIT;
      end
      ST_RX_WAIT: begin
        if (w_done) begin
          rx_valid_d = 1'b1;
          rx_data_d  = w_rbyte;
          state_d    = ST_POLL_REQ;
        end
      end
      ST_TX_WR: begin
        w_direct = 1'b1;
        if (!tx_valid_i) begin
          state_d = ST_POLL_REQ;
        end else if (w_accept) begin
          burst_d = burst_q + BURST_W'(1);
          // One THRE guarantees an empty TX FIFO, i.e. TX_BURST free slots
          if (burst_d == BURST_W'(TX_BURST)) begin
            state_d = ST_POLL_REQ;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and datapath registers, frozen while the clock enable is low
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_INIT;
      step_q      <= 3'd0;
      burst_q     <= '0;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      overrun_q   <= 1'b0;
    end else if (cke_i) begin
      state_q     <= state_d;
      step_q      <= step_d;
      burst_q     <= burst_d;
      init_done_q <= init_done_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_uart16550_stream_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_uart16550_stream_ctl
// Purpose  : Self-checking bench with a behavioural 16550 register slave,
//            a TX stream source and a transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iob_uart16550_stream_ctl;

  logic       clk_i = 1'b0;
  logic       cke_i;
  logic       arst_i;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       rx_ready_i;
  wire        tx_ready_o;
  wire        rx_valid_o;
  wire  [7:0] rx_data_o;
  wire        init_done_o;
  wire        rx_overrun_o;

  iob_uart16550_stream_ctl_if #(.ADDR_W(3), .DATA_W(32)) iob ();

  iob_uart16550_stream_ctl #(
    .ADDR_W   (3),
    .DATA_W   (32),
    .DIVISOR  (16'd27),
    .TX_BURST (16)
  ) dut (
    .clk_i        (clk_i),
    .cke_i        (cke_i),
    .arst_i       (arst_i),
    .iob          (iob),
    .tx_valid_i   (tx_valid_i),
    .tx_data_i    (tx_data_i),
    .tx_ready_o   (tx_ready_o),
    .rx_valid_o   (rx_valid_o),
    .rx_data_o    (rx_data_o),
    .rx_ready_i   (rx_ready_i),
    .init_done_o  (init_done_o),
    .rx_overrun_o (rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        txr;
    logic        idone;
  } txn_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } init_vec_t;

  txn_t       mon_q[$];
  txn_t       sb_q[$];
  logic [7:0] txq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         txr_cnt = 0;
  logic [7:0] lsr_val = 8'h00;
  logic [7:0] rbr_next = 8'hA5;
  logic [7:0] s_byte;
  logic [7:0] s_drop;
  bit         hold_ready = 1'b0;

  // Behavioural UART register slave: ready one cycle after avalid, rvalid
  // one cycle after a read is accepted, byte placed in lane addr[1:0]
  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      iob.iob_ready  <= 1'b0;
      iob.iob_rvalid <= 1'b0;
      iob.iob_rdata  <= 32'h0;
    end else begin
      iob.iob_rvalid <= 1'b0;
      if (iob.iob_avalid && iob.iob_ready) begin
        iob.iob_ready <= 1'b0;
        if (iob.iob_wstrb == 4'b0000) begin
          s_byte = (iob.iob_addr == 3'd5) ? lsr_val :
                   (iob.iob_addr == 3'd0) ? rbr_next : 8'h00;
          if (iob.iob_addr == 3'd0) rbr_next <= rbr_next + 8'd1;
          iob.iob_rvalid <= 1'b1;
          iob.iob_rdata  <= 32'(s_byte) << (8 * iob.iob_addr[1:0]);
        end
      end else begin
        iob.iob_ready <= iob.iob_avalid && !hold_ready;
      end
    end
  end

  // Bus monitor: every accepted request plus tx_ready pulse count
  always @(posedge clk_i) begin
    if (!arst_i) begin
      if (iob.iob_avalid && iob.iob_ready)
        mon_q.push_back('{iob.iob_addr, iob.iob_wdata, iob.iob_wstrb, tx_ready_o, init_done_o});
      if (tx_ready_o) txr_cnt++;
    end
  end

  // TX stream source: presents txq in order, advancing on each handshake
  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tx_valid_i <= 1'b0;
      tx_data_i  <= 8'h00;
    end else begin
      if (tx_valid_i && tx_ready_o) s_drop = txq.pop_front();
      if (txq.size() > 0) begin
        tx_valid_i <= 1'b1;
        tx_data_i  <= txq[0];
      end else begin
        tx_valid_i <= 1'b0;
        tx_data_i  <= 8'h00;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic txr, input logic idone);
    sb_q.push_back('{a, d, s, txr, idone});
  endtask

  task automatic get_txn(input bit skip_polls, output txn_t t, output bit ok);
    ok = 1'b0;
    t  = '{3'd0, 32'h0, 4'h0, 1'b0, 1'b0};
    for (int i = 0; i < 3000; i++) begin
      while (mon_q.size() > 0) begin
        t = mon_q.pop_front();
        if (!(skip_polls && t.wstrb == 4'b0000 && t.addr == 3'd5)) begin
          ok = 1'b1;
          return;
        end
      end
      @(negedge clk_i);
    end
  endtask

  // Pop the next expected transaction and compare it with the next observed one
  task automatic expect_next(input bit skip_polls, input string nm);
    txn_t e, a;
    bit   ok;
    e = sb_q.pop_front();
    get_txn(skip_polls, a, ok);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no transaction seen, expected addr %0d", nm, e.addr);
    end else begin
      chk({nm, ".addr"},  32'(a.addr),  32'(e.addr));
      chk({nm, ".wstrb"}, 32'(a.wstrb), 32'(e.wstrb));
      if (e.wstrb != 4'b0000) chk({nm, ".wdata"}, a.wdata, e.wdata);
      chk({nm, ".tx_ready"},  32'(a.txr),   32'(e.txr));
      chk({nm, ".init_done"}, 32'(a.idone), 32'(e.idone));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  init_vec_t tbl[6];

  initial begin
    int txc0, nrbr, npoll;
    cke_i      = 1'b1;
    arst_i     = 1'b1;
    rx_ready_i = 1'b0;
    tbl[0] = '{3'd3, 32'h8300_0000, 4'b1000};
    tbl[1] = '{3'd0, 32'h0000_001B, 4'b0001};
    tbl[2] = '{3'd1, 32'h0000_0000, 4'b0010};
    tbl[3] = '{3'd3, 32'h0300_0000, 4'b1000};
    tbl[4] = '{3'd2, 32'h0007_0000, 4'b0100};
    tbl[5] = '{3'd1, 32'h0000_0000, 4'b0010};

    // ---- reset state ----
    cycles(3);
    chk("rst.avalid",    32'(iob.iob_avalid), 32'd0);
    chk("rst.wstrb",     32'(iob.iob_wstrb),  32'd0);
    chk("rst.addr",      32'(iob.iob_addr),   32'd0);
    chk("rst.init_done", 32'(init_done_o),    32'd0);
    chk("rst.rx_valid",  32'(rx_valid_o),     32'd0);
    chk("rst.overrun",   32'(rx_overrun_o),   32'd0);
    arst_i = 1'b0;

    // ---- init sequence, table driven ----
    for (int i = 0; i < 6; i++) push_exp(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) expect_next(1'b0, $sformatf("init%0d", i));
    for (int i = 0; i < 50 && !init_done_o; i++) @(negedge clk_i);
    chk("init.done", 32'(init_done_o), 32'd1);
    push_exp(3'd5, 32'h0, 4'b0000, 1'b0, 1'b1);
    expect_next(1'b0, "first_poll");

    // ---- single TX byte ----
    mon_q.delete();
    txc0 = txr_cnt;
    txq.push_back(8'h55);
    lsr_val = 8'h60;
    push_exp(3'd0, 32'h55, 4'b0001, 1'b1, 1'b1);
    expect_next(1'b1, "tx_single");
    push_exp(3'd5, 32'h0, 4'b0000, 1'b0, 1'b1);
    expect_next(1'b0, "tx_single_poll");
    lsr_val = 8'h00;
    cycles(10);
    chk("tx_single.ready_pulses", 32'(txr_cnt - txc0), 32'd1);

    // ---- 20-byte TX burst: 16, LSR read, then 4 ----
    mon_q.delete();
    for (int i = 0; i < 20; i++) begin
      txq.push_back(8'h10 + 8'(i));
      push_exp(3'd0, 32'(8'h10 + 8'(i)), 4'b0001, 1'b1, 1'b1);
      if (i == 15) push_exp(3'd5, 32'h0, 4'b0000, 1'b0, 1'b1);
    end
    lsr_val = 8'h60;
    for (int i = 0; i < 16; i++) expect_next(i == 0, $sformatf("burst%0d", i));
    expect_next(1'b0, "burst_limit_poll");
    for (int i = 16; i < 20; i++) expect_next(i == 16, $sformatf("burst%0d", i));
    lsr_val = 8'h00;
    cycles(10);
    chk("burst.queue_empty", 32'(txq.size()), 32'd0);

    // ---- RX with backpressure ----
    mon_q.delete();
    lsr_val = 8'h01;
    push_exp(3'd0, 32'h0, 4'b0000, 1'b0, 1'b1);
    expect_next(1'b1, "rx_read0");
    for (int i = 0; i < 20 && !rx_valid_o; i++) @(negedge clk_i);
    chk("rx0.valid", 32'(rx_valid_o), 32'd1);
    chk("rx0.data",  32'(rx_data_o),  32'hA5);
    cycles(60);
    nrbr = 0;
    npoll = 0;
    foreach (mon_q[i]) begin
      if (mon_q[i].wstrb == 4'b0000 && mon_q[i].addr == 3'd0) nrbr++;
      if (mon_q[i].wstrb == 4'b0000 && mon_q[i].addr == 3'd5) npoll++;
    end
    chk("rx.no_read_while_full", 32'(nrbr), 32'd0);
    chk("rx.still_polling",      32'(npoll > 0), 32'd1);
    chk("rx0.data_held",         32'(rx_data_o), 32'hA5);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    chk("rx0.consumed", 32'(rx_valid_o), 32'd0);
    mon_q.delete();
    push_exp(3'd0, 32'h0, 4'b0000, 1'b0, 1'b1);
    expect_next(1'b1, "rx_read1");
    for (int i = 0; i < 20 && !rx_valid_o; i++) @(negedge clk_i);
    chk("rx1.valid", 32'(rx_valid_o), 32'd1);
    chk("rx1.data",  32'(rx_data_o),  32'hA6);
    lsr_val = 8'h00;
    cycles(10);
    rx_ready_i = 1'b1;
    cycles(2);
    rx_ready_i = 1'b0;

    // ---- RX over TX priority, then sticky overrun ----
    chk("prio.overrun_clear", 32'(rx_overrun_o), 32'd0);
    txq.push_back(8'h77);
    cycles(3);
    mon_q.delete();
    lsr_val = 8'h61;
    push_exp(3'd0, 32'h0,  4'b0000, 1'b0, 1'b1);
    push_exp(3'd0, 32'h77, 4'b0001, 1'b1, 1'b1);
    expect_next(1'b1, "prio_rbr_first");
    expect_next(1'b1, "prio_thr_after");
    chk("prio.rx_data", 32'(rx_data_o), 32'hA7);
    lsr_val = 8'h03;
    for (int i = 0; i < 40 && !rx_overrun_o; i++) @(negedge clk_i);
    chk("overrun.set", 32'(rx_overrun_o), 32'd1);
    lsr_val = 8'h00;
    cycles(30);
    chk("overrun.sticky", 32'(rx_overrun_o), 32'd1);
    rx_ready_i = 1'b1;
    cycles(3);
    rx_ready_i = 1'b0;

    // ---- clock enable low freezes a pending request ----
    hold_ready = 1'b1;
    cycles(6);
    cke_i = 1'b0;
    cycles(8);
    chk("cke.avalid_held", 32'(iob.iob_avalid), 32'd1);
    chk("cke.addr_held",   32'(iob.iob_addr),   32'd5);
    cke_i = 1'b1;
    hold_ready = 1'b0;
    mon_q.delete();
    push_exp(3'd5, 32'h0, 4'b0000, 1'b0, 1'b1);
    expect_next(1'b0, "cke_resume_poll");

    // ---- reset in the middle of a stalled write ----
    hold_ready = 1'b1;
    arst_i = 1'b1;
    @(negedge clk_i);
    arst_i = 1'b0;
    for (int i = 0; i < 20 && !iob.iob_avalid; i++) @(negedge clk_i);
    cycles(3);
    chk("midrst.pre_avalid", 32'(iob.iob_avalid), 32'd1);
    chk("midrst.pre_ready",  32'(iob.iob_ready),  32'd0);
    arst_i = 1'b1;
    #1;
    chk("midrst.avalid",    32'(iob.iob_avalid), 32'd0);
    chk("midrst.wstrb",     32'(iob.iob_wstrb),  32'd0);
    chk("midrst.init_done", 32'(init_done_o),    32'd0);
    chk("midrst.overrun",   32'(rx_overrun_o),   32'd0);
    chk("midrst.tx_ready",  32'(tx_ready_o),     32'd0);
    @(negedge clk_i);
    hold_ready = 1'b0;
    mon_q.delete();
    arst_i = 1'b0;
    push_exp(3'd3, 32'h8300_0000, 4'b1000, 1'b0, 1'b0);
    expect_next(1'b0, "reinit_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
